// File: rtl/spi_adc_responder.sv
// SPI mode-0 ADC emulator: shifts pattern words (constant/ramp/square/LFSR) out on MISO; pin edge to action is SYNC_STAGES+1 clk.
// No backpressure: the master paces frames. Optional LFSR pattern built only with SENSEEDGE_ADC_EMU_LFSR_EN defined.
module spi_adc_responder #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] amplitude,
   input  logic [4:0]        half_period,
   input  logic              spi_clk,
   input  logic              spi_cs_n,
   output logic              spi_miso,
   output logic              miso_oe,
   output logic              frame_done,
   output logic              short_frame,
   output logic [15:0]       frame_count
);

   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] FULL = BW'(DATA_W);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_END} state_t;
   state_t r_state, w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync;
   logic                   r_sclk_d, r_cs_d;
   logic                   w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
   logic                   w_load, w_shift, w_bit_inc, w_done, w_short;

   logic [DATA_W-1:0] r_shreg, r_acc, r_amp, w_word, w_amp_neg;
   logic [BW-1:0]     r_bit_cnt;
   logic [4:0]        r_phase, r_hp;
   logic [1:0]        r_mode;
   logic              r_sq_neg, r_miso, r_oe, r_done, r_short;
   logic [15:0]       r_count;
`ifdef SENSEEDGE_ADC_EMU_LFSR_EN
   logic [DATA_W-1:0] r_lfsr;
   logic              w_fb;
   assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
`endif

   // CS chain resets low so a CS_N already held low at reset release never looks like a fresh fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b0;
      end else begin
         r_sclk_sync[0] <= spi_clk;
         r_cs_sync[0]   <= spi_cs_n;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sclk_sync[i] <= r_sclk_sync[i-1];
            r_cs_sync[i]   <= r_cs_sync[i-1];
         end
         r_sclk_d <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_d   <= r_cs_sync[SYNC_STAGES-1];
      end
   end

   assign w_sclk_rise =  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
   assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] &  r_sclk_d;
   assign w_cs_rise   =  r_cs_sync[SYNC_STAGES-1]   & ~r_cs_d;
   assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1]   &  r_cs_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_bit_inc   = 1'b0;
      w_done      = 1'b0;
      w_short     = 1'b0;
      case (r_state)
         S_IDLE:  if (enable && w_cs_fall) w_state_nxt = S_LOAD;
         S_LOAD: begin
            if (!enable) w_state_nxt = S_IDLE;
            else begin
               w_load      = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (!enable)        w_state_nxt = S_IDLE;
            else if (w_cs_rise) w_state_nxt = S_END;
            else begin
               w_bit_inc = w_sclk_rise;
               w_shift   = w_sclk_fall;
            end
         end
         S_END: begin
            w_state_nxt = S_IDLE;
            if (enable) begin
               w_done  = (r_bit_cnt == FULL);
               w_short = (r_bit_cnt != FULL);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_amp_neg = ~amplitude + 1'b1;

   always_comb begin
      w_word = amplitude;
      case (mode)
         2'd1: w_word = r_acc;
         2'd2: w_word = r_sq_neg ? w_amp_neg : amplitude;
`ifdef SENSEEDGE_ADC_EMU_LFSR_EN
         2'd3: w_word = r_lfsr;
`endif
         default: w_word = amplitude;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_miso    <= 1'b0;
         r_oe      <= 1'b0;
         r_done    <= 1'b0;
         r_short   <= 1'b0;
         r_count   <= '0;
         r_mode    <= 2'd0;
         r_amp     <= '0;
         r_hp      <= 5'd1;
         r_acc     <= '0;
         r_phase   <= '0;
         r_sq_neg  <= 1'b0;
`ifdef SENSEEDGE_ADC_EMU_LFSR_EN
         r_lfsr    <= 16'hACE1;
`endif
      end else begin
         r_done  <= w_done;
         r_short <= w_short;
         r_oe    <= (w_state_nxt == S_SHIFT);
         // Shift register holds the bits after the one currently on MISO.
         if (w_load) begin
            r_miso    <= w_word[DATA_W-1];
            r_shreg   <= {w_word[DATA_W-2:0], 1'b0};
            r_bit_cnt <= '0;
            r_mode    <= mode;
            r_amp     <= amplitude;
            r_hp      <= (half_period == 5'd0) ? 5'd1 : half_period;
         end else if (w_shift) begin
            r_miso  <= (r_bit_cnt >= FULL) ? 1'b0 : r_shreg[DATA_W-1];
            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
         end else if (w_state_nxt != S_SHIFT) begin
            r_miso <= 1'b0;
         end
         if (w_bit_inc && (r_bit_cnt != FULL)) r_bit_cnt <= r_bit_cnt + 1'b1;
         if (w_done) begin
            r_count <= r_count + 16'd1;
            case (r_mode)
               2'd1: r_acc <= r_acc + r_amp;
               2'd2: begin
                  if (r_phase + 5'd1 == r_hp) begin
                     r_phase  <= '0;
                     r_sq_neg <= ~r_sq_neg;
                  end else begin
                     r_phase <= r_phase + 5'd1;
                  end
               end
`ifdef SENSEEDGE_ADC_EMU_LFSR_EN
               2'd3: r_lfsr <= {r_lfsr[DATA_W-2:0], w_fb};
`endif
               default: ;
            endcase
         end
      end
   end

   assign spi_miso    = r_miso;
   assign miso_oe     = r_oe;
   assign frame_done  = r_done;
   assign short_frame = r_short;
   assign frame_count = r_count;

endmodule
